mem_arbiter: RTL and testbench

- Shares the single-port CPU memory (one address, one write port, one read port) between instruction fetch and load/store.
- Sits between the fetch stage, the load/store stage and the memory array.
- Grants one access per cycle with a pipelined one-cycle response.
- Data accesses have priority; a starvation counter guarantees fetch progress.

---
 rtl/cpu_mem_pkg.sv | 26 ++
 rtl/arb_priority_starve.sv | 55 +++++
 rtl/mem_arbiter.sv | 114 +++++++++++
 tb/tb_mem_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cpu_mem_pkg
// Description : Shared widths, FSM encoding and grant-select type for the
//               CPU memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_mem_pkg;

    localparam int unsigned c_ADDR_W = 32;
    localparam int unsigned c_DATA_W = 32;

    // Response-due-next-cycle state encoding
    localparam logic [1:0] c_IDLE   = 2'b00;
    localparam logic [1:0] c_RESP_I = 2'b01;
    localparam logic [1:0] c_RESP_D = 2'b10;

    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_I    = 2'b01,
        GNT_D    = 2'b10
    } gnt_sel_e;

endpackage
`default_nettype wire

// File: rtl/arb_priority_starve.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : arb_priority_starve
// Description : Data-priority chooser with a saturating fetch starvation
//               counter that hands the slot to fetch once it hits the limit.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_priority_starve
    import cpu_mem_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     instr_req,
    input  logic     data_req,
    output gnt_sel_e gnt_sel
);

    localparam logic [3:0] c_STARVE_LIMIT = 4'(STARVE_MAX);

    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;

    always_comb begin
        gnt_sel = GNT_NONE;
        if (rst_n) begin
            if (data_req && instr_req) begin
                gnt_sel = (r_cnt == c_STARVE_LIMIT) ? GNT_I : GNT_D;
            end else if (data_req) begin
                gnt_sel = GNT_D;
            end else if (instr_req) begin
                gnt_sel = GNT_I;
            end
        end
    end

    always_comb begin
        w_cnt_nxt = 4'd0;
        if (instr_req && (gnt_sel != GNT_I)) begin
            w_cnt_nxt = (r_cnt < c_STARVE_LIMIT) ? r_cnt + 4'd1 : r_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= 4'd0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one single-port memory between fetch and load/store,
//               one grant per cycle with a one-cycle pipelined response.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_W     = c_ADDR_W,
    parameter int unsigned DATA_W     = c_DATA_W,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_req,
    input  logic [ADDR_W-1:0] instr_addr,
    output logic              instr_gnt,
    output logic              instr_ready,
    output logic [DATA_W-1:0] instr_rdata,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_gnt,
    output logic              data_ready,
    output logic [DATA_W-1:0] data_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall
);

    gnt_sel_e          w_gnt_sel;
    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_resp_load;
    logic [ADDR_W-1:0] r_mem_addr_last;
    logic [DATA_W-1:0] r_instr_rdata;
    logic [DATA_W-1:0] r_data_rdata;
    logic              r_stall;
    logic              w_instr_resp;
    logic              w_data_resp;

    arb_priority_starve #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .instr_req (instr_req),
        .data_req  (data_req),
        .gnt_sel   (w_gnt_sel)
    );

    assign instr_gnt = (w_gnt_sel == GNT_I);
    assign data_gnt  = (w_gnt_sel == GNT_D);
    assign mem_we    = data_gnt & data_we;
    assign mem_wdata = data_wdata;

    always_comb begin
        mem_addr = r_mem_addr_last;
        if (instr_gnt) begin
            mem_addr = instr_addr;
        end else if (data_gnt) begin
            mem_addr = data_addr;
        end
    end

    always_comb begin
        w_state_nxt = c_IDLE;
        case (w_gnt_sel)
            GNT_I:   w_state_nxt = c_RESP_I;
            GNT_D:   w_state_nxt = c_RESP_D;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Gating with rst_n drops a response that was due in the reset cycle
    assign w_instr_resp = rst_n && (r_state == c_RESP_I);
    assign w_data_resp  = rst_n && (r_state == c_RESP_D);

    assign instr_ready = w_instr_resp;
    assign data_ready  = w_data_resp;
    assign instr_rdata = w_instr_resp ? mem_rdata : r_instr_rdata;
    assign data_rdata  = (w_data_resp && r_resp_load) ? mem_rdata : r_data_rdata;
    assign stall       = r_stall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state         <= c_IDLE;
            r_resp_load     <= 1'b0;
            r_mem_addr_last <= '0;
            r_instr_rdata   <= '0;
            r_data_rdata    <= '0;
            r_stall         <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_resp_load     <= data_gnt & ~data_we;
            r_mem_addr_last <= mem_addr;
            if (w_instr_resp) begin
                r_instr_rdata <= mem_rdata;
            end
            if (w_data_resp && r_resp_load) begin
                r_data_rdata <= mem_rdata;
            end
            r_stall <= (instr_req & ~instr_gnt) | (data_req & ~data_gnt);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed bench for mem_arbiter with a one-cycle-latency
//               memory model and an instr_addr stability monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        instr_gnt;
    logic        instr_ready;
    logic [31:0] instr_rdata;
    logic        data_req;
    logic        data_we;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_gnt;
    logic        data_ready;
    logic [31:0] data_rdata;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        stall;

    int n_cmp = 0;
    int n_err = 0;
    int n_proto = 0;

    logic [31:0] mem [0:255];
    logic        pend_q = 1'b0;
    logic [31:0] pend_addr_q = '0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .STARVE_MAX (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_req   (instr_req),
        .instr_addr  (instr_addr),
        .instr_gnt   (instr_gnt),
        .instr_ready (instr_ready),
        .instr_rdata (instr_rdata),
        .data_req    (data_req),
        .data_we     (data_we),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_gnt    (data_gnt),
        .data_ready  (data_ready),
        .data_rdata  (data_rdata),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .stall       (stall)
    );

    // Single-port memory: write on the edge, read data one cycle later
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr[7:0]] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr[7:0]];
    end

    // A pending (ungranted) fetch must keep its address stable
    always @(posedge clk) begin
        if (rst_n && pend_q && instr_req && (instr_addr !== pend_addr_q)) begin
            n_proto <= n_proto + 1;
        end
        pend_q      <= rst_n & instr_req & ~instr_gnt;
        pend_addr_q <= instr_addr;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_i(input logic req, input logic [31:0] addr);
        instr_req  = req;
        instr_addr = addr;
    endtask

    task automatic set_d(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd);
        data_req   = req;
        data_we    = we;
        data_addr  = addr;
        data_wdata = wd;
    endtask

    initial begin
        rst_n = 1'b0;
        set_i(1'b0, 32'h0);
        set_d(1'b1, 1'b1, 32'h44, 32'h0BAD_0BAD);
        tick();
        tick();
        settle();
        // Reset state, with a store request held during reset
        chk("rst_instr_ready", {31'b0, instr_ready}, 32'd0);
        chk("rst_data_ready", {31'b0, data_ready}, 32'd0);
        chk("rst_instr_rdata", instr_rdata, 32'd0);
        chk("rst_data_rdata", data_rdata, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_data_gnt", {31'b0, data_gnt}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);

        // Preload through the store path
        tick();
        rst_n = 1'b1;
        set_d(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
        settle();
        chk("pre_gnt", {31'b0, data_gnt}, 32'd1);
        chk("pre_mem_we", {31'b0, mem_we}, 32'd1);
        chk("pre_mem_addr", mem_addr, 32'h10);
        tick();
        set_d(1'b1, 1'b1, 32'h30, 32'hAAAA_0001);
        settle();
        chk("pre_ready0", {31'b0, data_ready}, 32'd1);
        tick();
        set_d(1'b0, 1'b0, 32'h0, 32'h0);
        settle();
        chk("pre_ready1", {31'b0, data_ready}, 32'd1);
        tick();

        // Fetch only
        set_i(1'b1, 32'h10);
        settle();
        chk("f_gnt", {31'b0, instr_gnt}, 32'd1);
        chk("f_dgnt", {31'b0, data_gnt}, 32'd0);
        chk("f_mem_addr", mem_addr, 32'h10);
        chk("f_stall0", {31'b0, stall}, 32'd0);
        tick();
        set_i(1'b0, 32'h0);
        settle();
        chk("f_ready", {31'b0, instr_ready}, 32'd1);
        chk("f_rdata", instr_rdata, 32'hDEAD_BEEF);
        chk("f_stall1", {31'b0, stall}, 32'd0);
        chk("f_idle_addr_hold", mem_addr, 32'h10);
        tick();
        settle();
        chk("f_ready_end", {31'b0, instr_ready}, 32'd0);
        chk("f_rdata_hold", instr_rdata, 32'hDEAD_BEEF);

        // Store then load
        set_d(1'b1, 1'b1, 32'h20, 32'h1234_5678);
        settle();
        chk("sl_gnt0", {31'b0, data_gnt}, 32'd1);
        chk("sl_we0", {31'b0, mem_we}, 32'd1);
        chk("sl_wdata0", mem_wdata, 32'h1234_5678);
        tick();
        set_d(1'b1, 1'b0, 32'h20, 32'h0);
        settle();
        chk("sl_ready1", {31'b0, data_ready}, 32'd1);
        chk("sl_gnt1", {31'b0, data_gnt}, 32'd1);
        chk("sl_we1", {31'b0, mem_we}, 32'd0);
        chk("sl_store_rdata_hold", data_rdata, 32'd0);
        tick();
        set_d(1'b0, 1'b0, 32'h0, 32'h0);
        settle();
        chk("sl_ready2", {31'b0, data_ready}, 32'd1);
        chk("sl_rdata2", data_rdata, 32'h1234_5678);
        tick();
        settle();
        chk("sl_ready3", {31'b0, data_ready}, 32'd0);
        chk("sl_rdata_hold", data_rdata, 32'h1234_5678);

        // Both requesting: data wins cycles 0-3, fetch wins cycle 4
        set_i(1'b1, 32'h10);
        set_d(1'b1, 1'b0, 32'h20, 32'h0);
        for (int c = 0; c < 5; c++) begin
            settle();
            chk($sformatf("st_cnt_c%0d", c), {28'b0, dut.u_arb.r_cnt}, c);
            chk($sformatf("st_igs_c%0d", c), {31'b0, instr_gnt}, (c == 4) ? 32'd1 : 32'd0);
            chk($sformatf("st_dgs_c%0d", c), {31'b0, data_gnt}, (c == 4) ? 32'd0 : 32'd1);
            chk($sformatf("st_stall_c%0d", c), {31'b0, stall}, (c >= 1) ? 32'd1 : 32'd0);
            tick();
        end
        set_i(1'b0, 32'h0);
        settle();
        chk("st_cnt_c5", {28'b0, dut.u_arb.r_cnt}, 32'd0);
        chk("st_iready_c5", {31'b0, instr_ready}, 32'd1);
        chk("st_irdata_c5", instr_rdata, 32'hDEAD_BEEF);
        chk("st_dgnt_c5", {31'b0, data_gnt}, 32'd1);
        tick();
        set_d(1'b0, 1'b0, 32'h0, 32'h0);
        settle();
        chk("st_dready_c6", {31'b0, data_ready}, 32'd1);
        chk("st_drdata_c6", data_rdata, 32'h1234_5678);
        tick();

        // Back-to-back I, D, I
        set_i(1'b1, 32'h10);
        settle();
        chk("bb_gnt_i0", {31'b0, instr_gnt}, 32'd1);
        tick();
        set_i(1'b0, 32'h0);
        set_d(1'b1, 1'b0, 32'h30, 32'h0);
        settle();
        chk("bb_gnt_d1", {31'b0, data_gnt}, 32'd1);
        chk("bb_iready1", {31'b0, instr_ready}, 32'd1);
        chk("bb_irdata1", instr_rdata, 32'hDEAD_BEEF);
        tick();
        set_d(1'b0, 1'b0, 32'h0, 32'h0);
        set_i(1'b1, 32'h20);
        settle();
        chk("bb_gnt_i2", {31'b0, instr_gnt}, 32'd1);
        chk("bb_dready2", {31'b0, data_ready}, 32'd1);
        chk("bb_iready2", {31'b0, instr_ready}, 32'd0);
        chk("bb_drdata2", data_rdata, 32'hAAAA_0001);
        tick();
        set_i(1'b0, 32'h0);
        settle();
        chk("bb_iready3", {31'b0, instr_ready}, 32'd1);
        chk("bb_dready3", {31'b0, data_ready}, 32'd0);
        chk("bb_irdata3", instr_rdata, 32'h1234_5678);
        tick();

        // Reset in the cycle after a load grant
        set_d(1'b1, 1'b0, 32'h10, 32'h0);
        settle();
        chk("rl_gnt", {31'b0, data_gnt}, 32'd1);
        tick();
        rst_n = 1'b0;
        set_d(1'b0, 1'b0, 32'h0, 32'h0);
        settle();
        chk("rl_ready_in_rst", {31'b0, data_ready}, 32'd0);
        tick();
        settle();
        chk("rl_ready_after", {31'b0, data_ready}, 32'd0);
        chk("rl_drdata", data_rdata, 32'd0);
        chk("rl_irdata", instr_rdata, 32'd0);
        chk("rl_stall", {31'b0, stall}, 32'd0);
        tick();
        rst_n = 1'b1;
        set_d(1'b1, 1'b0, 32'h10, 32'h0);
        settle();
        chk("rl_regnt", {31'b0, data_gnt}, 32'd1);
        tick();
        set_d(1'b0, 1'b0, 32'h0, 32'h0);
        settle();
        chk("rl_reready", {31'b0, data_ready}, 32'd1);
        chk("rl_rerdata", data_rdata, 32'hDEAD_BEEF);
        tick();

        // Store presented while reset is low must not write
        rst_n = 1'b0;
        set_d(1'b1, 1'b1, 32'h30, 32'hBAD0_BAD0);
        settle();
        chk("rs_gnt", {31'b0, data_gnt}, 32'd0);
        chk("rs_we", {31'b0, mem_we}, 32'd0);
        tick();
        rst_n = 1'b1;
        set_d(1'b1, 1'b0, 32'h30, 32'h0);
        settle();
        chk("rs_load_gnt", {31'b0, data_gnt}, 32'd1);
        tick();
        set_d(1'b0, 1'b0, 32'h0, 32'h0);
        settle();
        chk("rs_ready", {31'b0, data_ready}, 32'd1);
        chk("rs_old_data", data_rdata, 32'hAAAA_0001);
        tick();

        chk("proto_instr_addr_stable", n_proto, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
